spike_rate_decoder: RTL and testbench

Receive-side counterpart of the LIF neuron. Converts a neuron's 1-bit spike train back into an 8-bit magnitude by counting spikes over a fixed window of clock cycles. Each window result is delivered on a valid/ready output port. Sits downstream of a neuron's spike output, feeding readout logic or the next layer's current input.

---
 rtl/snn_pkg.sv | 19 +
 rtl/spike_sat_counter.sv | 35 +++
 rtl/spike_rate_decoder.sv | 148 ++++++++++++++
 tb/tb_spike_rate_decoder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// snn_pkg: definitions shared by the spiking-neuron blocks.
//   state_t   - decoder FSM state (IDLE, COUNT)
//   CNT_W_DEF - default count width, the same width as the neuron's current
//   sat_inc   - saturating increment on a 32-bit carrier, clamped at max_val
package snn_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int CNT_W_DEF = 8;

  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/spike_sat_counter.sv
// spike_sat_counter: CNT_W-bit up-counter that holds at 2^CNT_W-1.
// Ports:
//   clk, rst_n - clock and synchronous active-low reset
//   clr        - clear to zero; takes priority over inc
//   inc        - advance by one, saturating
//   cnt        - current count
module spike_sat_counter
  import snn_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= CNT_W'(sat_inc(32'(r_cnt), CNT_MAX));
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spike-level cycles over a WINDOW-cycle window and
// delivers each window's count on a valid/ready port.
// Optional feature macro: SPIKE_DEC_ISI_EN adds the inter-spike-interval outputs.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   enable      - run; low returns to IDLE and discards the partial window
//   spike       - spike level, each high cycle counts once
//   rate        - count of the last completed window (saturating)
//   rate_valid  - rate holds an unconsumed result
//   rate_ready  - consumer accepts rate when rate_valid && rate_ready
//   overrun     - sticky, a window result was dropped
//   isi         - (SPIKE_DEC_ISI_EN) cycles between the last two spikes
//   isi_valid   - (SPIKE_DEC_ISI_EN) one-cycle pulse when isi updates
//   busy        - high while in COUNT
//
// state | meaning
// IDLE  | decoder stopped, window and spike counters held at zero
// COUNT | counting spikes, win_cnt walks 0..WINDOW-1
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             spike,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun,
`ifdef SPIKE_DEC_ISI_EN
  output logic [CNT_W-1:0] isi,
  output logic             isi_valid,
`endif
  output logic             busy
);

  localparam int              WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [31:0]     CNT_MAX  = (32'd1 << CNT_W) - 32'd1;

  state_t           r_state;
  logic [WIN_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_rate;
  logic             r_rate_valid;
  logic             r_overrun;

  logic [CNT_W-1:0] w_spike_cnt;
  logic [CNT_W-1:0] w_final;
  logic             w_win_end;
  logic             w_cnt_clr;
  logic             w_cnt_inc;

  // The first enabled cycle in IDLE is already window cycle 0, so the window
  // logic keys on enable rather than on the registered state.
  assign w_win_end = enable && (r_win_cnt == WIN_LAST);
  assign w_cnt_clr = !enable || w_win_end;
  assign w_cnt_inc = enable && spike;
  // Window-end cycle's own spike is folded in here since the counter clears.
  assign w_final   = spike ? CNT_W'(sat_inc(32'(w_spike_cnt), CNT_MAX)) : w_spike_cnt;

  spike_sat_counter #(.CNT_W(CNT_W)) u_spike_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_cnt_clr),
    .inc   (w_cnt_inc),
    .cnt   (w_spike_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_win_cnt    <= '0;
      r_rate       <= '0;
      r_rate_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      // IDLE->COUNT on enable, COUNT->IDLE whenever enable drops.
      r_state <= enable ? COUNT : IDLE;

      if (w_cnt_clr) begin
        r_win_cnt <= '0;
      end else begin
        r_win_cnt <= r_win_cnt + 1'b1;
      end

      if (w_win_end) begin
        if (!r_rate_valid || rate_ready) begin
          r_rate       <= w_final;
          r_rate_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_rate_valid && rate_ready) begin
        r_rate_valid <= 1'b0;
      end
    end
  end

  assign rate       = r_rate;
  assign rate_valid = r_rate_valid;
  assign overrun    = r_overrun;
  assign busy       = (r_state == COUNT);

`ifdef SPIKE_DEC_ISI_EN
  logic [CNT_W-1:0] r_isi;
  logic             r_isi_valid;
  logic             r_isi_seen;
  logic [CNT_W-1:0] w_isi_cnt;
  logic             w_isi_clr;
  logic             w_isi_inc;
  logic             w_isi_hit;

  // Counter restarts on every spike cycle and only runs once a first spike
  // has been seen, so at the next spike it holds (interval - 1).
  assign w_isi_clr = !enable || spike;
  assign w_isi_inc = enable && r_isi_seen;
  assign w_isi_hit = enable && spike && r_isi_seen;

  spike_sat_counter #(.CNT_W(CNT_W)) u_isi_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_isi_clr),
    .inc   (w_isi_inc),
    .cnt   (w_isi_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_isi       <= '0;
      r_isi_valid <= 1'b0;
      r_isi_seen  <= 1'b0;
    end else begin
      r_isi_valid <= w_isi_hit;
      r_isi_seen  <= enable && (r_isi_seen || spike);
      if (w_isi_hit) begin
        r_isi <= CNT_W'(sat_inc(32'(w_isi_cnt), CNT_MAX));
      end
    end
  end

  assign isi       = r_isi;
  assign isi_valid = r_isi_valid;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: two instances (WINDOW=16/CNT_W=8 and
// WINDOW=32/CNT_W=4) share stimulus; an integer-level window model predicts
// every output each cycle, and directed phases pin known values.
module tb_spike_rate_decoder;

  localparam int W0 = 16;
  localparam int C0 = 8;
  localparam int W1 = 32;
  localparam int C1 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic spike = 1'b0;
  logic rate_ready = 1'b0;

  logic [C0-1:0] rate0;
  logic          v0, ov0, busy0;
  logic [C1-1:0] rate1;
  logic          v1, ov1, busy1;
`ifdef SPIKE_DEC_ISI_EN
  logic [C0-1:0] isi0;
  logic          iv0;
  logic [C1-1:0] isi1;
  logic          iv1;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spike_rate_decoder #(.WINDOW(W0), .CNT_W(C0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .spike(spike),
    .rate(rate0), .rate_valid(v0), .rate_ready(rate_ready), .overrun(ov0),
`ifdef SPIKE_DEC_ISI_EN
    .isi(isi0), .isi_valid(iv0),
`endif
    .busy(busy0)
  );

  spike_rate_decoder #(.WINDOW(W1), .CNT_W(C1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .spike(spike),
    .rate(rate1), .rate_valid(v1), .rate_ready(rate_ready), .overrun(ov1),
`ifdef SPIKE_DEC_ISI_EN
    .isi(isi1), .isi_valid(iv1),
`endif
    .busy(busy1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_win[2] = '{W0, W1};
  int m_max[2] = '{(1 << C0) - 1, (1 << C1) - 1};
  int m_pos[2];
  int m_cnt[2];
  int m_rate[2];
  bit m_valid[2];
  bit m_ov[2];
  bit m_busy[2];
  bit m_we;
  int m_fin;
  bit model_ok = 1'b0;
`ifdef SPIKE_DEC_ISI_EN
  int m_t, m_last, m_isi;
  bit m_seen, m_iv;
`endif

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_pos[k] = 0; m_cnt[k] = 0; m_rate[k] = 0;
        m_valid[k] = 0; m_ov[k] = 0; m_busy[k] = 0;
      end else begin
        m_we = 0;
        m_fin = 0;
        if (!enable) begin
          m_pos[k] = 0; m_cnt[k] = 0; m_busy[k] = 0;
        end else begin
          m_busy[k] = 1;
          m_cnt[k] += int'(spike);
          if (m_pos[k] == m_win[k] - 1) begin
            m_we = 1;
            m_fin = (m_cnt[k] > m_max[k]) ? m_max[k] : m_cnt[k];
            m_pos[k] = 0;
            m_cnt[k] = 0;
          end else begin
            m_pos[k]++;
          end
        end
        if (m_we) begin
          if (!m_valid[k] || rate_ready) begin
            m_rate[k] = m_fin;
            m_valid[k] = 1;
          end else begin
            m_ov[k] = 1;
          end
        end else if (m_valid[k] && rate_ready) begin
          m_valid[k] = 0;
        end
      end
    end
`ifdef SPIKE_DEC_ISI_EN
    if (!rst_n) begin
      m_t = 0; m_last = 0; m_isi = 0; m_seen = 0; m_iv = 0;
    end else begin
      m_iv = 0;
      if (!enable) begin
        m_seen = 0;
      end else if (spike) begin
        if (m_seen) begin
          m_isi = ((m_t - m_last) > m_max[0]) ? m_max[0] : (m_t - m_last);
          m_iv = 1;
        end
        m_seen = 1;
        m_last = m_t;
      end
      m_t++;
    end
`endif
    model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("rate0", int'(rate0), m_rate[0]);
      chk("valid0", int'(v0), int'(m_valid[0]));
      chk("overrun0", int'(ov0), int'(m_ov[0]));
      chk("busy0", int'(busy0), int'(m_busy[0]));
      chk("rate1", int'(rate1), m_rate[1]);
      chk("valid1", int'(v1), int'(m_valid[1]));
      chk("overrun1", int'(ov1), int'(m_ov[1]));
      chk("busy1", int'(busy1), int'(m_busy[1]));
`ifdef SPIKE_DEC_ISI_EN
      chk("isi0", int'(isi0), m_isi);
      chk("isi_valid0", int'(iv0), int'(m_iv));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; spike = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    cyc(2);
    chk("rst_rate", int'(rate0), 0);
    chk("rst_valid", int'(v0), 0);
    chk("rst_overrun", int'(ov0), 0);
    chk("rst_busy", int'(busy0), 0);
    rst_n = 1'b1;

    // Spike held high, consumer always ready.
    enable = 1'b1; spike = 1'b1; rate_ready = 1'b1;
    cyc(15);
    chk("full_pre_valid", int'(v0), 0);
    cyc(1);
    chk("full_rate_w1", int'(rate0), 16);
    chk("full_valid_w1", int'(v0), 1);
    cyc(16);
    chk("full_rate_w2", int'(rate0), 16);
    chk("full_valid_w2", int'(v0), 1);
    chk("sat_rate_cntw4", int'(rate1), 15);
    chk("sat_valid_cntw4", int'(v1), 1);

    // Spike every 4th cycle.
    do_reset();
    enable = 1'b1; rate_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      spike = (i % 4 == 0);
      cyc(1);
      if (i == 15) chk("every4_rate_w1", int'(rate0), 4);
    end
    chk("every4_rate_w2", int'(rate0), 4);
    chk("every4_rate_dut1", int'(rate1), 8);

    // Backpressure: second result dropped.
    do_reset();
    enable = 1'b1; spike = 1'b1; rate_ready = 1'b0;
    cyc(16);
    chk("bp_rate_first", int'(rate0), 16);
    chk("bp_overrun_first", int'(ov0), 0);
    cyc(16);
    chk("bp_rate_held", int'(rate0), 16);
    chk("bp_overrun_set", int'(ov0), 1);
    rate_ready = 1'b1;
    cyc(1);
    chk("bp_valid_drop", int'(v0), 0);
    chk("bp_overrun_sticky", int'(ov0), 1);
    enable = 1'b0;
    cyc(3);
    chk("bp_overrun_idle", int'(ov0), 1);
    do_reset();
    chk("bp_overrun_cleared", int'(ov0), 0);

    // Enable dropped at window cycle 7 after 5 spikes.
    rate_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      spike = (i < 5);
      cyc(1);
    end
    enable = 1'b0; spike = 1'b0;
    cyc(3);
    chk("abort_no_result", int'(v0), 0);
    chk("abort_busy", int'(busy0), 0);
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      spike = (i == 2 || i == 9 || i == 10);
      cyc(1);
    end
    chk("abort_next_rate", int'(rate0), 3);
    chk("abort_next_valid", int'(v0), 1);

    // Reset mid-window.
    spike = 1'b1;
    cyc(8);
    rst_n = 1'b0;
    cyc(1);
    chk("midrst_rate", int'(rate0), 0);
    chk("midrst_valid", int'(v0), 0);
    chk("midrst_busy", int'(busy0), 0);
    rst_n = 1'b1;

`ifdef SPIKE_DEC_ISI_EN
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 25; i++) begin
      spike = (i == 3 || i == 8 || i == 20);
      cyc(1);
      if (i == 3) chk("isi_first_nopulse", int'(iv0), 0);
      if (i == 8) begin
        chk("isi_pulse1", int'(iv0), 1);
        chk("isi_val1", int'(isi0), 5);
      end
      if (i == 20) begin
        chk("isi_pulse2", int'(iv0), 1);
        chk("isi_val2", int'(isi0), 12);
      end
    end
    enable = 1'b0; spike = 1'b0;
    cyc(2);
`endif

    // Randomized phases with varying spike density and backpressure.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int ph;
      ph = n / 1000;
      rst_n      = ($urandom_range(0, 299) != 0);
      enable     = ($urandom_range(0, 59) != 0);
      case (ph)
        0: spike = ($urandom_range(0, 3) == 0);
        1: spike = ($urandom_range(0, 9) != 0);
        2: spike = ($urandom_range(0, 1) == 0);
        default: spike = ($urandom_range(0, 19) == 0);
      endcase
      rate_ready = (ph == 2) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) != 0);
      cyc(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
